booth_seq_mult: RTL
===================

BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 SHALL have parameter WIDTH: default 8; operand width in bits; must be even and >= 4, otherwise elaboration fails.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a multiplication; sampled only when idle or in the done cycle.
REQ-005 SHALL have port mode  input  1  operand interpretation: 1 = two's-complement signed, 0 = unsigned; sampled with start.
REQ-006 SHALL have port a  input  WIDTH  multiplicand; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  multiplier; sampled with start.
REQ-008 SHALL have port busy  output  1  high while an iteration sequence is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; res is valid in the same cycle.
REQ-010 SHALL have port res  output  2*WIDTH  product; holds its value until the next completion.

Function
REQ-011 SHALL implement a sequential radix-4 Booth multiplier with states IDLE, RUN and DONE.
REQ-012 SHALL latch a, b and mode on the edge where start is accepted; input changes after that edge SHALL NOT affect the result.
REQ-013 SHALL extend both operands to WIDTH+2 bits: sign-extend when mode=1, zero-extend when mode=0.
REQ-014 SHALL perform ITER = WIDTH/2+1 iterations, one per cycle; each iteration recodes 3 multiplier bits to a digit in {-2,-1,0,+1,+2}, adds that multiple of the multiplicand to the accumulator, then arithmetic-shifts right by 2.
REQ-015 SHALL produce res as the exact product, truncated to the low 2*WIDTH bits (always exact for both modes).
REQ-016 SHALL compute the -1 and -2 digit multiples as full-width two's complement with no overflow loss; the most negative operand (e.g. -128 at WIDTH=8) SHALL give a correct result.
REQ-017 SHALL, in IDLE with start=1: load the operands, clear the iteration counter, move to RUN and raise busy on the same edge.
REQ-018 SHALL, in RUN: perform one iteration per edge; on the edge completing iteration ITER, update res, drop busy, enter DONE and raise done.
REQ-019 SHALL give a latency of ITER edges from start acceptance to done high (5 cycles at WIDTH=8), independent of operand values and mode.
REQ-020 SHALL keep done high for exactly one cycle, in the DONE state only.
REQ-021 SHALL, in DONE with start=0: return to IDLE on the next edge.
REQ-022 SHALL, in DONE with start=1: accept the new operation immediately (go to RUN), allowing back-to-back operations with no idle gap.
REQ-023 SHALL ignore start while in RUN: no reload, no restart, no effect on the result.
REQ-024 SHALL NOT clear res when start is accepted; res changes only on completion or reset.
REQ-025 SHALL never have busy and done high in the same cycle.

Reset
REQ-026 SHALL, while rst=1 (asynchronously): state = IDLE, busy = 0, done = 0, res = 0, counter and internal registers cleared.
REQ-027 SHALL abort any in-progress operation when rst is asserted mid-RUN; no done pulse follows for the aborted operation.
REQ-028 SHALL ignore start while rst=1; the first start after rst deasserts SHALL be accepted normally.

Verification (WIDTH=8)
REQ-029 SHALL cover: mode=1, a=-7, b=-5 -> done exactly 5 cycles after start; res=0x0023 (35); busy high for those 5 cycles.
REQ-030 SHALL cover: mode=1, a=-128, b=-128 -> res=0x4000; mode=1, a=127, b=-128 -> res=0xC080 (-16256).
REQ-031 SHALL cover: a=0xFF, b=0xFF -> res=0xFE01 when mode=0, and res=0x0001 when mode=1.
REQ-032 SHALL cover: start pulsed again in cycle 2 of RUN with different operands -> ignored; first result is delivered unchanged.
REQ-033 SHALL cover: start held high through the done cycle -> second operation begins at once; second done 5 cycles after the first; res holds the first product until then.
REQ-034 SHALL cover: rst asserted during iteration 3 -> busy=0, done=0, res=0 immediately, with no done pulse; a following start with 4*5 -> res=0x0014.

Source files
------------

// File: rtl/booth_seq_mult.sv
// ---------------------------------------------------------------------------
// booth_seq_mult
//
// Sequential radix-4 Booth multiplier. Each operation runs WIDTH/2+1
// iterations, one per clock. Each iteration recodes three multiplier bits
// into a digit in {-2,-1,0,+1,+2} and adds that multiple of the multiplicand
// to the accumulator. The accumulator and multiplier are then arithmetically
// shifted right by two bits. Signed and unsigned operation share one datapath:
// both operands are extended by two bits, using sign or zero extension, so the
// recoding always operates on a non-overflowing signed value.
//
// Ports
//   clk    in   1         sole clock, rising edge
//   rst    in   1         asynchronous active-high reset
//   start  in   1         request; sampled in IDLE and in the DONE cycle
//   mode   in   1         1 = two's-complement signed, 0 = unsigned
//   a      in   WIDTH     multiplicand (latched with start)
//   b      in   WIDTH     multiplier   (latched with start)
//   busy   out  1         high while iterations are in progress
//   done   out  1         one-cycle completion pulse, res valid with it
//   res    out  2*WIDTH   product, held until the next completion
// ---------------------------------------------------------------------------
module booth_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] res
);

  // Extended operand width, accumulator width and iteration count.
  // The accumulator has two bits of headroom over the extended operand
  // so that the +/-2 multiples and the running sum never overflow.
  localparam int XW   = WIDTH + 2;
  localparam int HW   = WIDTH + 4;
  localparam int ITER = WIDTH / 2 + 1;
  localparam int CW   = $clog2(ITER + 1);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
      $error("booth_seq_mult: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [XW-1:0]        m_q, m_d;      // extended multiplicand
  logic [HW-1:0]        h_q, h_d;      // accumulator (high part of product)
  logic [XW-1:0]        l_q, l_d;      // multiplier, shifted out as product low bits
  logic                 x_q, x_d;      // bit shifted out below l_q (Booth b[-1])
  logic [CW-1:0]        cnt_q, cnt_d;  // iterations completed
  logic [2*WIDTH-1:0]   res_q, res_d;

  // Operand extension: sign extend in signed mode, zero extend otherwise.
  logic [XW-1:0] a_ext;
  logic [XW-1:0] b_ext;
  assign a_ext = mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
  assign b_ext = mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

  // Multiplicand sign-extended to accumulator width, so that the negative
  // multiples are formed at full width without losing the top bit. This
  // matters for the most negative operand.
  logic [HW-1:0] m_hw;
  assign m_hw = {{(HW - XW){m_q[XW-1]}}, m_q};

  // Radix-4 Booth recoding of {b[i+1], b[i], b[i-1]}.
  logic [HW-1:0] addend;
  always_comb begin
    addend = '0;
    unique case ({l_q[1:0], x_q})
      3'b001, 3'b010: addend = m_hw;
      3'b011:         addend = m_hw << 1;
      3'b100:         addend = -(m_hw << 1);
      3'b101, 3'b110: addend = -m_hw;
      default:        addend = '0;
    endcase
  end

  // One iteration: add, then arithmetic shift of {h, l, x} right by two.
  logic [HW-1:0]      sum;
  logic [HW-1:0]      h_sh;
  logic [XW-1:0]      l_sh;
  logic [2*WIDTH-1:0] product;
  assign sum  = h_q + addend;
  assign h_sh = {{2{sum[HW-1]}}, sum[HW-1:2]};
  assign l_sh = {sum[1:0], l_q[XW-1:2]};
  // After the last shift, the low XW bits of the product are in l and the
  // rest of the product is in the bottom of h.
  assign product = {h_sh[WIDTH-3:0], l_sh};

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      h_q     <= '0;
      l_q     <= '0;
      x_q     <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      h_q     <= h_d;
      l_q     <= l_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Next-state logic and datapath control.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    h_d     = h_q;
    l_d     = l_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    res_d   = res_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = a_ext;
          h_d     = '0;
          l_d     = b_ext;
          x_d     = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // start is deliberately not examined here.
        h_d   = h_sh;
        l_d   = l_sh;
        x_d   = l_q[1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          res_d   = product;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // A start in the done cycle begins the next operation with no gap.
        if (start) begin
          m_d     = a_ext;
          h_d     = '0;
          l_d     = b_ext;
          x_d     = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // busy and done are decoded from distinct states, so they are never high together.
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign res  = res_q;

endmodule
